// File: rtl/vscale_dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// vscale_dmem_arbiter_if
//
// Bundles the signals around the shared data-memory arbiter: the NUM_CORES
// HASTI master ports (flattened, slice i belongs to core i), the single HASTI
// slave port towards the shared memory, and the data-phase observation
// outputs.
//
// Modports:
//   slave  - the arbiter's view. It is the slave of every core dmem port and
//            drives the shared-memory request bus (m_* in, s_* request out,
//            s_* response in, data_owner/data_valid out).
//   master - the surrounding system's view (cores plus memory), the exact
//            mirror of the slave modport.
// ---------------------------------------------------------------------------
interface vscale_dmem_arbiter_if #(
  parameter int NUM_CORES = 4,
  parameter int IDX_W     = 2
);

  // Core-side (master port) signals
  logic [NUM_CORES*32-1:0] m_haddr;
  logic [NUM_CORES-1:0]    m_hwrite;
  logic [NUM_CORES*3-1:0]  m_hsize;
  logic [NUM_CORES*4-1:0]  m_hprot;
  logic [NUM_CORES*2-1:0]  m_htrans;
  logic [NUM_CORES*32-1:0] m_hwdata;
  logic [NUM_CORES*32-1:0] m_hrdata;
  logic [NUM_CORES-1:0]    m_hready;
  logic [NUM_CORES-1:0]    m_hresp;

  // Shared-memory (slave port) signals
  logic [31:0]             s_haddr;
  logic                    s_hwrite;
  logic [2:0]              s_hsize;
  logic [2:0]              s_hburst;
  logic                    s_hmastlock;
  logic [3:0]              s_hprot;
  logic [1:0]              s_htrans;
  logic [31:0]             s_hwdata;
  logic [31:0]             s_hrdata;
  logic                    s_hready;
  logic                    s_hresp;

  // Data-phase observation
  logic [IDX_W-1:0]        data_owner;
  logic                    data_valid;

  modport slave (
    input  m_haddr, m_hwrite, m_hsize, m_hprot, m_htrans, m_hwdata,
    output m_hrdata, m_hready, m_hresp,
    output s_haddr, s_hwrite, s_hsize, s_hburst, s_hmastlock, s_hprot,
    output s_htrans, s_hwdata,
    input  s_hrdata, s_hready, s_hresp,
    output data_owner, data_valid
  );

  modport master (
    output m_haddr, m_hwrite, m_hsize, m_hprot, m_htrans, m_hwdata,
    input  m_hrdata, m_hready, m_hresp,
    input  s_haddr, s_hwrite, s_hsize, s_hburst, s_hmastlock, s_hprot,
    input  s_htrans, s_hwdata,
    output s_hrdata, s_hready, s_hresp,
    input  data_owner, data_valid
  );

endinterface

// File: rtl/vscale_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// vscale_dmem_arbiter
//
// Shares one HASTI (AHB-lite) data-memory slave between NUM_CORES vscale
// core dmem master ports.
//
// Every master port owns a one-entry capture register, so a core can start a
// NONSEQ transfer whenever its m_hready is high without ever seeing the
// arbitration. Captured requests are handed to the slave in round-robin order
// through a registered address stage; the slave data phase is routed back to
// the core that owns it (write data muxed in, read data broadcast, response
// steered to the owner only).
//
// Per-core life cycle: IDLE -> PEND (captured) -> ADDR (in slave address
// stage) -> DATA (in slave data phase) -> IDLE, or straight back to PEND when
// the core chains a new NONSEQ on the cycle its data phase completes.
//
// Ports:
//   clk      - single clock, all state updates on the rising edge
//   reset_n  - asynchronous, active-low reset; discards any in-flight transfer
//   bus      - vscale_dmem_arbiter_if.slave:
//                m_haddr/m_hwrite/m_hsize/m_hprot/m_htrans/m_hwdata (in)
//                m_hrdata/m_hready/m_hresp                          (out)
//                s_haddr/s_hwrite/s_hsize/s_hburst/s_hmastlock/
//                s_hprot/s_htrans/s_hwdata                          (out)
//                s_hrdata/s_hready/s_hresp                          (in)
//                data_owner/data_valid                              (out)
//
// Parameters:
//   NUM_CORES - number of master ports, at least 2
//   IDX_W     - width of a core index, must equal clog2(NUM_CORES)
// ---------------------------------------------------------------------------
module vscale_dmem_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int IDX_W     = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  vscale_dmem_arbiter_if.slave bus
);

  // Per-core state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PEND = 2'd1;
  localparam logic [1:0] ST_ADDR = 2'd2;
  localparam logic [1:0] ST_DATA = 2'd3;

  // HTRANS / HBURST encodings used here
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  // Starting the pointer at the last core makes core 0 the first winner.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CORES - 1);

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  logic [1:0]       r_state     [NUM_CORES];

  // Capture registers: payload only, never read unless the core is PEND
  logic [31:0]      r_cap_addr  [NUM_CORES];
  logic             r_cap_write [NUM_CORES];
  logic [2:0]       r_cap_size  [NUM_CORES];
  logic [3:0]       r_cap_prot  [NUM_CORES];

  // Slave address stage
  logic [31:0]      r_s_haddr;
  logic             r_s_hwrite;
  logic [2:0]       r_s_hsize;
  logic [3:0]       r_s_hprot;
  logic [1:0]       r_s_htrans;
  logic [IDX_W-1:0] r_addr_idx;

  // Slave data phase
  logic [IDX_W-1:0] r_data_owner;
  logic             r_data_valid;

  // Round-robin pointer: index of the most recent grant
  logic [IDX_W-1:0] r_rr_ptr;

  // -------------------------------------------------------------------------
  // Combinational signals
  // -------------------------------------------------------------------------
  logic [31:0]          w_m_haddr  [NUM_CORES];
  logic [2:0]           w_m_hsize  [NUM_CORES];
  logic [3:0]           w_m_hprot  [NUM_CORES];
  logic [1:0]           w_m_htrans [NUM_CORES];
  logic [31:0]          w_m_hwdata [NUM_CORES];

  logic [NUM_CORES-1:0] w_m_hready;
  logic [NUM_CORES-1:0] w_m_hresp;
  logic [NUM_CORES-1:0] w_accept;

  logic [IDX_W-1:0]     w_scan_idx [NUM_CORES];
  logic                 w_win_found;
  logic [IDX_W-1:0]     w_win_idx;

  logic                 w_slot_free;
  logic                 w_addr_busy;

  // Unflatten the per-core buses so the rest of the logic can index by core.
  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      w_m_haddr[i]  = bus.m_haddr [32*i +: 32];
      w_m_hsize[i]  = bus.m_hsize [3*i  +: 3];
      w_m_hprot[i]  = bus.m_hprot [4*i  +: 4];
      w_m_htrans[i] = bus.m_htrans[2*i  +: 2];
      w_m_hwdata[i] = bus.m_hwdata[32*i +: 32];
    end
  end

  // A core sees hready low while its request waits or sits in the address
  // stage; in its own data phase it sees the slave's hready directly.
  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      case (r_state[i])
        ST_IDLE: w_m_hready[i] = 1'b1;
        ST_DATA: w_m_hready[i] = bus.s_hready;
        default: w_m_hready[i] = 1'b0;
      endcase
      w_accept[i] = w_m_hready[i] && (w_m_htrans[i] == HTRANS_NONSEQ);
    end
  end

  // The address stage can take a new entry when it is empty or the slave is
  // sampling the current one this cycle.
  assign w_slot_free = (r_s_htrans == HTRANS_IDLE) || bus.s_hready;
  assign w_addr_busy = (r_s_htrans == HTRANS_NONSEQ);

  // Scan order starts just after the last grant, wrapping around.
  always_comb begin
    for (int k = 0; k < NUM_CORES; k++) begin
      w_scan_idx[k] = IDX_W'((int'(r_rr_ptr) + k + 1) % NUM_CORES);
    end
  end

  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (!w_win_found && (r_state[w_scan_idx[k]] == ST_PEND)) begin
        w_win_found = 1'b1;
        w_win_idx   = w_scan_idx[k];
      end
    end
  end

  // Response goes only to the core that owns the active data phase.
  always_comb begin
    w_m_hresp = '0;
    if (r_data_valid) begin
      w_m_hresp[r_data_owner] = bus.s_hresp;
    end
  end

  // -------------------------------------------------------------------------
  // Capture stage: payload registers, loaded on request acceptance
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CORES; i++) begin
      if (w_accept[i]) begin
        r_cap_addr[i]  <= w_m_haddr[i];
        r_cap_write[i] <= bus.m_hwrite[i];
        r_cap_size[i]  <= w_m_hsize[i];
        r_cap_prot[i]  <= w_m_hprot[i];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Control: per-core state, address stage, data-phase tracking
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        r_state[i] <= ST_IDLE;
      end
      r_s_haddr    <= '0;
      r_s_hwrite   <= 1'b0;
      r_s_hsize    <= '0;
      r_s_hprot    <= '0;
      r_s_htrans   <= HTRANS_IDLE;
      r_addr_idx   <= '0;
      r_data_owner <= '0;
      r_data_valid <= 1'b0;
      r_rr_ptr     <= LAST_IDX;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        case (r_state[i])
          ST_IDLE: begin
            if (w_accept[i]) begin
              r_state[i] <= ST_PEND;
            end
          end
          ST_PEND: begin
            if (w_slot_free && w_win_found && (w_win_idx == IDX_W'(i))) begin
              r_state[i] <= ST_ADDR;
            end
          end
          ST_ADDR: begin
            if (bus.s_hready) begin
              r_state[i] <= ST_DATA;
            end
          end
          default: begin
            // ST_DATA: a NONSEQ presented on the completing cycle is
            // captured straight away (w_accept already implies s_hready).
            if (bus.s_hready) begin
              r_state[i] <= w_accept[i] ? ST_PEND : ST_IDLE;
            end
          end
        endcase
      end

      // Address stage: load the winner, or go idle; hold while stalled.
      if (w_slot_free) begin
        if (w_win_found) begin
          r_s_haddr  <= r_cap_addr[w_win_idx];
          r_s_hwrite <= r_cap_write[w_win_idx];
          r_s_hsize  <= r_cap_size[w_win_idx];
          r_s_hprot  <= r_cap_prot[w_win_idx];
          r_s_htrans <= HTRANS_NONSEQ;
          r_addr_idx <= w_win_idx;
          r_rr_ptr   <= w_win_idx;
        end else begin
          r_s_htrans <= HTRANS_IDLE;
        end
      end

      // Data phase: follows the address stage whenever the slave is ready.
      if (bus.s_hready) begin
        if (w_addr_busy) begin
          r_data_owner <= r_addr_idx;
          r_data_valid <= 1'b1;
        end else begin
          r_data_owner <= '0;
          r_data_valid <= 1'b0;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.m_hrdata    = {NUM_CORES{bus.s_hrdata}};
  assign bus.m_hready    = w_m_hready;
  assign bus.m_hresp     = w_m_hresp;

  assign bus.s_haddr     = r_s_haddr;
  assign bus.s_hwrite    = r_s_hwrite;
  assign bus.s_hsize     = r_s_hsize;
  assign bus.s_hburst    = HBURST_SINGLE;
  assign bus.s_hmastlock = 1'b0;
  assign bus.s_hprot     = r_s_hprot;
  assign bus.s_htrans    = r_s_htrans;
  assign bus.s_hwdata    = w_m_hwdata[r_data_owner];

  assign bus.data_owner  = r_data_owner;
  assign bus.data_valid  = r_data_valid;

endmodule

// File: tb/tb_vscale_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vscale_dmem_arbiter
//
// Directed bench for vscale_dmem_arbiter with 4 cores. A table of per-cycle
// records gives the inputs of each cycle and the outputs expected in that
// same cycle; hand-written sequences cover reset behaviour.
// ---------------------------------------------------------------------------
module tb_vscale_dmem_arbiter;

  localparam int NC = 4;
  localparam int IW = 2;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  vscale_dmem_arbiter_if #(.NUM_CORES(NC), .IDX_W(IW)) bus ();

  vscale_dmem_arbiter #(.NUM_CORES(NC), .IDX_W(IW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  // Fixed per-core payloads
  logic [31:0] core_addr [NC] = '{32'h0000_0010, 32'h0000_0020, 32'h0000_0100, 32'h0000_0300};
  logic [31:0] core_wd   [NC] = '{32'h1111_1111, 32'hA5A5_A5A5, 32'h3333_3333, 32'h4444_4444};

  typedef struct {
    logic [7:0]  htrans;
    logic [3:0]  hwrite;
    logic        s_rdy;
    logic        s_rsp;
    logic [31:0] rdata;
    logic [3:0]  e_hready;
    logic [1:0]  e_htrans;
    logic [31:0] e_haddr;
    logic        e_hwrite;
    logic        e_dv;
    logic [1:0]  e_own;
    logic [3:0]  e_hresp;
  } vec_t;

  localparam int NV = 30;
  vec_t vec [NV];

  int n_total = 0;
  int n_pass  = 0;

  function automatic vec_t mk(
    input logic [7:0] ht, input logic [3:0] hw, input logic rdy, input logic rsp,
    input logic [31:0] rd, input logic [3:0] ehr, input logic [1:0] eht,
    input logic [31:0] ea, input logic ew, input logic edv, input logic [1:0] eo,
    input logic [3:0] ersp);
    vec_t v;
    v.htrans = ht;  v.hwrite = hw;  v.s_rdy = rdy; v.s_rsp = rsp; v.rdata = rd;
    v.e_hready = ehr; v.e_htrans = eht; v.e_haddr = ea; v.e_hwrite = ew;
    v.e_dv = edv; v.e_own = eo; v.e_hresp = ersp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic drive(input logic [7:0] ht, input logic [3:0] hw, input logic rdy,
                       input logic rsp, input logic [31:0] rd);
    bus.m_htrans = ht;
    bus.m_hwrite = hw;
    bus.s_hready = rdy;
    bus.s_hresp  = rsp;
    bus.s_hrdata = rd;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " hready"}, 32'(bus.m_hready), 32'h0000_000F);
    chk({tag, " htrans"}, 32'(bus.s_htrans), 32'h0);
    chk({tag, " haddr"},  bus.s_haddr,       32'h0);
    chk({tag, " hwrite"}, 32'(bus.s_hwrite), 32'h0);
    chk({tag, " dvalid"}, 32'(bus.data_valid), 32'h0);
    chk({tag, " owner"},  32'(bus.data_owner), 32'h0);
    chk({tag, " hresp"},  32'(bus.m_hresp),  32'h0);
  endtask

  initial begin
    for (int i = 0; i < NC; i++) begin
      bus.m_haddr [32*i +: 32] = core_addr[i];
      bus.m_hwdata[32*i +: 32] = core_wd[i];
    end
    bus.m_hsize = 12'h492;   // size 2 (word) on every core
    bus.m_hprot = 16'h3333;
    drive(8'h00, 4'h0, 1'b1, 1'b0, 32'h0);

    // ----------------------------------------------------------------------
    // Vector table. Row r: inputs during cycle r, outputs expected in it.
    // Cols: htrans hwrite s_rdy s_rsp rdata | hready htrans haddr hwrite dv own hresp
    // ----------------------------------------------------------------------
    // Idle after reset, then fairness: all four issue together, core 0 chains
    vec[0]  = mk(8'h00, 4'h0, 1'b1, 1'b0, 32'h0, 4'hF, 2'd0, 32'h000, 1'b0, 1'b0, 2'd0, 4'h0);
    vec[1]  = mk(8'hAA, 4'h0, 1'b1, 1'b0, 32'h0, 4'hF, 2'd0, 32'h000, 1'b0, 1'b0, 2'd0, 4'h0);
    vec[2]  = mk(8'h00, 4'h0, 1'b1, 1'b0, 32'h0, 4'h0, 2'd0, 32'h000, 1'b0, 1'b0, 2'd0, 4'h0);
    vec[3]  = mk(8'h00, 4'h0, 1'b1, 1'b0, 32'h0, 4'h0, 2'd2, 32'h010, 1'b0, 1'b0, 2'd0, 4'h0);
    vec[4]  = mk(8'h02, 4'h0, 1'b1, 1'b0, 32'h0, 4'h1, 2'd2, 32'h020, 1'b0, 1'b1, 2'd0, 4'h0);
    vec[5]  = mk(8'h00, 4'h0, 1'b1, 1'b0, 32'h0, 4'h2, 2'd2, 32'h100, 1'b0, 1'b1, 2'd1, 4'h0);
    vec[6]  = mk(8'h00, 4'h0, 1'b1, 1'b0, 32'h0, 4'h6, 2'd2, 32'h300, 1'b0, 1'b1, 2'd2, 4'h0);
    vec[7]  = mk(8'h00, 4'h0, 1'b1, 1'b0, 32'h0, 4'hE, 2'd2, 32'h010, 1'b0, 1'b1, 2'd3, 4'h0);
    vec[8]  = mk(8'h00, 4'h0, 1'b1, 1'b0, 32'h0, 4'hF, 2'd0, 32'h010, 1'b0, 1'b1, 2'd0, 4'h0);
    vec[9]  = mk(8'h00, 4'h0, 1'b1, 1'b0, 32'h0, 4'hF, 2'd0, 32'h010, 1'b0, 1'b0, 2'd0, 4'h0);
    // Wait states: core 1 write, core 0 pending, slave stalls 3 cycles
    vec[10] = mk(8'h08, 4'h2, 1'b1, 1'b0, 32'h0, 4'hF, 2'd0, 32'h010, 1'b0, 1'b0, 2'd0, 4'h0);
    vec[11] = mk(8'h02, 4'h0, 1'b1, 1'b0, 32'h0, 4'hD, 2'd0, 32'h010, 1'b0, 1'b0, 2'd0, 4'h0);
    vec[12] = mk(8'h00, 4'h0, 1'b1, 1'b0, 32'h0, 4'hC, 2'd2, 32'h020, 1'b1, 1'b0, 2'd0, 4'h0);
    vec[13] = mk(8'h00, 4'h0, 1'b0, 1'b0, 32'h0, 4'hC, 2'd2, 32'h010, 1'b0, 1'b1, 2'd1, 4'h0);
    vec[14] = mk(8'h00, 4'h0, 1'b0, 1'b0, 32'h0, 4'hC, 2'd2, 32'h010, 1'b0, 1'b1, 2'd1, 4'h0);
    vec[15] = mk(8'h00, 4'h0, 1'b0, 1'b0, 32'h0, 4'hC, 2'd2, 32'h010, 1'b0, 1'b1, 2'd1, 4'h0);
    vec[16] = mk(8'h00, 4'h0, 1'b1, 1'b0, 32'h0, 4'hE, 2'd2, 32'h010, 1'b0, 1'b1, 2'd1, 4'h0);
    vec[17] = mk(8'h00, 4'h0, 1'b1, 1'b0, 32'h0, 4'hF, 2'd0, 32'h010, 1'b0, 1'b1, 2'd0, 4'h0);
    vec[18] = mk(8'h00, 4'h0, 1'b1, 1'b0, 32'h0, 4'hF, 2'd0, 32'h010, 1'b0, 1'b0, 2'd0, 4'h0);
    // Error routing: core 3 gets ERROR while core 1 sits in the address stage
    vec[19] = mk(8'h80, 4'h0, 1'b1, 1'b0, 32'h0, 4'hF, 2'd0, 32'h010, 1'b0, 1'b0, 2'd0, 4'h0);
    vec[20] = mk(8'h08, 4'h0, 1'b1, 1'b0, 32'h0, 4'h7, 2'd0, 32'h010, 1'b0, 1'b0, 2'd0, 4'h0);
    vec[21] = mk(8'h00, 4'h0, 1'b1, 1'b0, 32'h0, 4'h5, 2'd2, 32'h300, 1'b0, 1'b0, 2'd0, 4'h0);
    vec[22] = mk(8'h00, 4'h0, 1'b1, 1'b1, 32'h0BAD_0BAD, 4'hD, 2'd2, 32'h020, 1'b0, 1'b1, 2'd3, 4'h8);
    vec[23] = mk(8'h00, 4'h0, 1'b1, 1'b0, 32'h0, 4'hF, 2'd0, 32'h020, 1'b0, 1'b1, 2'd1, 4'h0);
    vec[24] = mk(8'h00, 4'h0, 1'b1, 1'b0, 32'h0, 4'hF, 2'd0, 32'h020, 1'b0, 1'b0, 2'd0, 4'h0);
    // Single read by core 2 of 0x100
    vec[25] = mk(8'h20, 4'h0, 1'b1, 1'b0, 32'h0, 4'hF, 2'd0, 32'h020, 1'b0, 1'b0, 2'd0, 4'h0);
    vec[26] = mk(8'h00, 4'h0, 1'b1, 1'b0, 32'h0, 4'hB, 2'd0, 32'h020, 1'b0, 1'b0, 2'd0, 4'h0);
    vec[27] = mk(8'h00, 4'h0, 1'b1, 1'b0, 32'h0, 4'hB, 2'd2, 32'h100, 1'b0, 1'b0, 2'd0, 4'h0);
    vec[28] = mk(8'h00, 4'h0, 1'b1, 1'b0, 32'hDEAD_BEEF, 4'hF, 2'd0, 32'h100, 1'b0, 1'b1, 2'd2, 4'h0);
    vec[29] = mk(8'h00, 4'h0, 1'b1, 1'b0, 32'h0, 4'hF, 2'd0, 32'h100, 1'b0, 1'b0, 2'd0, 4'h0);

    // ---------------- Reset held with random inputs ----------------
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      drive(8'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), $urandom);
      @(negedge clk);
      chk_reset_vals($sformatf("rst%0d", c));
    end
    chk("rst hburst", 32'(bus.s_hburst), 32'h0);
    chk("rst hmastlock", 32'(bus.s_hmastlock), 32'h0);
    drive(8'h00, 4'h0, 1'b1, 1'b0, 32'h0);
    #2 reset_n = 1'b1;

    // ---------------- Table-driven cycles ----------------
    for (int r = 0; r < NV; r++) begin
      @(posedge clk); #1;
      drive(vec[r].htrans, vec[r].hwrite, vec[r].s_rdy, vec[r].s_rsp, vec[r].rdata);
      @(negedge clk);
      chk($sformatf("row%0d hready", r), 32'(bus.m_hready), 32'(vec[r].e_hready));
      chk($sformatf("row%0d htrans", r), 32'(bus.s_htrans), 32'(vec[r].e_htrans));
      chk($sformatf("row%0d haddr", r),  bus.s_haddr,       vec[r].e_haddr);
      chk($sformatf("row%0d hwrite", r), 32'(bus.s_hwrite), 32'(vec[r].e_hwrite));
      chk($sformatf("row%0d dvalid", r), 32'(bus.data_valid), 32'(vec[r].e_dv));
      chk($sformatf("row%0d owner", r),  32'(bus.data_owner), 32'(vec[r].e_own));
      chk($sformatf("row%0d hresp", r),  32'(bus.m_hresp),  32'(vec[r].e_hresp));
      chk($sformatf("row%0d hwdata", r), bus.s_hwdata,      core_wd[vec[r].e_own]);
      chk($sformatf("row%0d hrdata2", r), bus.m_hrdata[95:64], vec[r].rdata);
      chk($sformatf("row%0d hburst", r), 32'({bus.s_hmastlock, bus.s_hburst}), 32'h0);
    end

    // ---------------- Mid-transfer asynchronous reset ----------------
    // Core 0 request; slave stalls its data phase, reset lands between edges.
    @(posedge clk); #1; drive(8'h02, 4'h0, 1'b1, 1'b0, 32'h0);
    @(posedge clk); #1; drive(8'h00, 4'h0, 1'b1, 1'b0, 32'h0);
    @(posedge clk); #1; drive(8'h00, 4'h0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("mid addr phase htrans", 32'(bus.s_htrans), 32'h2);
    @(posedge clk); #1; drive(8'h00, 4'h0, 1'b0, 1'b1, 32'h0);
    @(negedge clk);
    chk("mid data phase dvalid", 32'(bus.data_valid), 32'h1);
    chk("mid data phase hready", 32'(bus.m_hready), 32'hE);
    chk("mid data phase hresp",  32'(bus.m_hresp),  32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk_reset_vals("async rst");
    @(negedge clk);
    drive(8'h00, 4'h0, 1'b1, 1'b0, 32'h0);
    #2 reset_n = 1'b1;

    // ---------------- Single read after release ----------------
    @(posedge clk); #1; drive(8'h20, 4'h0, 1'b1, 1'b0, 32'h0);       // t
    @(negedge clk);
    chk("post t hready", 32'(bus.m_hready), 32'hF);
    @(posedge clk); #1; drive(8'h00, 4'h0, 1'b1, 1'b0, 32'h0);       // t+1
    @(negedge clk);
    chk("post t+1 htrans", 32'(bus.s_htrans), 32'h0);
    chk("post t+1 hready", 32'(bus.m_hready), 32'hB);
    @(posedge clk); #1; drive(8'h00, 4'h0, 1'b1, 1'b0, 32'h0);       // t+2
    @(negedge clk);
    chk("post t+2 htrans", 32'(bus.s_htrans), 32'h2);
    chk("post t+2 haddr",  bus.s_haddr,       32'h100);
    @(posedge clk); #1; drive(8'h00, 4'h0, 1'b1, 1'b0, 32'hDEAD_BEEF); // t+3
    @(negedge clk);
    chk("post t+3 hready", 32'(bus.m_hready), 32'hF);
    chk("post t+3 owner",  32'(bus.data_owner), 32'h2);
    chk("post t+3 dvalid", 32'(bus.data_valid), 32'h1);
    chk("post t+3 hrdata2", bus.m_hrdata[95:64], 32'hDEAD_BEEF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vscale_dmem_arbiter.md
Name: vscale_dmem_arbiter

Overview:
- Shares one HASTI (AHB-lite) data-memory slave between NUM_CORES vscale_core dmem master ports. Used in the multicore top, between the per-core dmem bridges and the shared memory.
- Each master port has a one-entry capture register, so any master can issue at any time without seeing arbitration.
- Captured requests go to the slave in round-robin order through a registered address stage. The slave data phase is routed back to the owning master.

Parameters:
- NUM_CORES, 4, number of master ports; at least 2.
- IDX_W, 2, width of a core index; equals clog2(NUM_CORES).

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- m_haddr  in  NUM_CORES*32  per-master address; slice i = [32*i+31:32*i]
- m_hwrite  in  NUM_CORES  per-master write flag
- m_hsize  in  NUM_CORES*3  per-master transfer size
- m_hprot  in  NUM_CORES*4  per-master protection bits
- m_htrans  in  NUM_CORES*2  per-master transfer type
- m_hwdata  in  NUM_CORES*32  per-master write data, driven in that master's data phase
- m_hrdata  out  NUM_CORES*32  per-master read data
- m_hready  out  NUM_CORES  per-master ready
- m_hresp  out  NUM_CORES  per-master response; 1 = ERROR
- s_haddr  out  32  slave address
- s_hwrite  out  1  slave write flag
- s_hsize  out  3  slave transfer size
- s_hburst  out  3  slave burst type
- s_hmastlock  out  1  slave lock
- s_hprot  out  4  slave protection bits
- s_htrans  out  2  slave transfer type
- s_hwdata  out  32  slave write data
- s_hrdata  in  32  slave read data
- s_hready  in  1  slave ready
- s_hresp  in  1  slave response
- data_owner  out  IDX_W  index of the master in the slave data phase; 0 when none
- data_valid  out  1  1 when a slave data phase is active

Behaviour:
- Per-master state takes one of four values:
  - IDLE: no transfer outstanding.
  - PEND: request captured, waiting for the address stage.
  - ADDR: request is in the slave address-stage registers.
  - DATA: transfer is in the slave data phase.
- Request acceptance:
  - Only m_htrans = NONSEQ (2'b10) is a request. IDLE, BUSY and SEQ are ignored.
  - A master's request is accepted in any cycle where its m_hready = 1. On acceptance, addr, write, size and prot are captured and the state goes to PEND.
- m_hready[i] by state:
  - IDLE: 1.
  - PEND or ADDR: 0.
  - DATA: equals s_hready.
  - The master's data phase therefore stretches until its slave data phase completes. Masters hold m_hwdata while m_hready is low.
- Address slot: the slot is free when s_htrans = IDLE or s_hready = 1.
- Loading the slot:
  - When the slot is free, the winning PEND master is loaded into s_haddr, s_hwrite, s_hsize and s_hprot, with s_htrans = NONSEQ. That master goes to ADDR and rr_ptr takes its index.
  - If no master is PEND, s_htrans is loaded with IDLE.
  - When the slot is not free, the s_* address outputs hold.
- Winner selection: the first PEND index found by scanning cyclically from rr_ptr+1.
- Fixed slave outputs: s_hburst = SINGLE (3'b000) and s_hmastlock = 0 at all times.
- Phase advance on s_hready = 1:
  - The ADDR master goes to DATA; data_owner takes its index and data_valid goes to 1.
  - The DATA master goes to IDLE, or straight to PEND if it presents a new NONSEQ in that same cycle.
  - If no master is in ADDR, data_valid goes to 0.
  - Both advances occur in the same cycle when both are present.
- Data-phase routing:
  - s_hwdata = m_hwdata slice of data_owner.
  - s_hrdata is broadcast to every m_hrdata slice.
  - m_hresp[data_owner] = s_hresp when data_valid = 1. All other m_hresp are 0.
  - An ERROR response completes the transfer like OKAY; the arbiter does not retry.
- Latency:
  - Request presented in cycle t: captured at end of t, slave address phase in t+2, slave data phase from t+3.
  - With no contention and zero wait states, m_hready[i] = 1 in t+3, so the master's data phase lasts 3 cycles.
- Contention: at most one address and one data transfer are outstanding at the slave. Other requests wait in PEND. No master can be starved; the worst-case wait is NUM_CORES-1 grants.
- Reset (asserted asynchronously at any time, including mid-transfer):
  - All masters go to IDLE and m_hready goes to all 1s. m_hresp = 0.
  - s_htrans = IDLE, s_haddr = 0, s_hwrite = 0, s_hsize = 0, s_hprot = 0.
  - data_valid = 0, data_owner = 0, rr_ptr = NUM_CORES-1 so core 0 wins first.
  - Any in-flight transfer is discarded.

Test Plan:
- Reset: hold reset_n = 0 with random inputs -> m_hready = 4'b1111, s_htrans = 2'b00, data_valid = 0. Deassert -> no slave activity until a NONSEQ appears.
- Single read: core 2 NONSEQ to 0x100 in cycle t, slave zero-wait, s_hrdata = 0xDEADBEEF -> s_haddr = 0x100 with NONSEQ in t+2; m_hready[2] = 1 and m_hrdata slice 2 = 0xDEADBEEF in t+3; data_owner = 2.
- Fairness: all 4 cores issue NONSEQ in the same cycle after reset -> slave address phases in core order 0, 1, 2, 3 on consecutive cycles. Core 0 reissues immediately -> it is served after core 3.
- Wait states: core 1 write of 0xA5A5A5A5 while core 0 is PEND, slave holds s_hready = 0 for 3 cycles -> s_haddr/s_htrans for core 0 stable throughout; s_hwdata = 0xA5A5A5A5; m_hready[1] low until slave ready.
- Error routing: slave returns s_hresp = 1 on core 3's transfer while core 1 is in ADDR -> m_hresp = 4'b1000 only. Core 1 then completes with m_hresp[1] = 0.
- Mid-operation reset: pull reset_n low while in a slave data phase -> outputs reach reset values without a clock edge. After release, the next request follows single-read latency.
